// File: rtl/i2c_pkg.sv
// Shared types and constants for the WM8731 control-port responder.
// Holds the FSM state encoding and the codec register map.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ACK_ADDR,
        ST_BYTE1,
        ST_ACK1,
        ST_BYTE2,
        ST_ACK2,
        ST_NACK,
        ST_WAIT_STOP
    } i2c_rsp_state_e;

    localparam logic [6:0] R_AAPC  = 7'd4;
    localparam logic [6:0] R_DAPC  = 7'd5;
    localparam logic [6:0] R_PDC   = 7'd6;
    localparam logic [6:0] R_DAIF  = 7'd7;
    localparam logic [6:0] R_SC    = 7'd8;
    localparam logic [6:0] R_AC    = 7'd9;
    localparam logic [6:0] R_RESET = 7'd15;

    localparam logic [7:0] WM8731_WR_ADDR = 8'h34;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchroniser with SCL edge and START/STOP condition detection.
// The flops reset to 1 so an idle (pulled-up) bus produces no spurious events.
module i2c_bus_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sclk,
    input  logic i_sdat,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_sda_s,
    output logic o_start_det,
    output logic o_stop_det
);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_d;
    logic                   r_sda_d;
    logic                   w_scl_s;
    logic                   w_sda_s;

    assign w_scl_s = r_scl_sync[SYNC_STAGES-1];
    assign w_sda_s = r_sda_sync[SYNC_STAGES-1];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_sclk};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sdat};
            r_scl_d    <= w_scl_s;
            r_sda_d    <= w_sda_s;
        end
    end

    // SDA transitions only count as conditions while SCL is stably high
    assign o_scl_rise  =  w_scl_s & ~r_scl_d;
    assign o_scl_fall  = ~w_scl_s &  r_scl_d;
    assign o_sda_s     =  w_sda_s;
    assign o_start_det =  w_scl_s &  r_scl_d &  r_sda_d & ~w_sda_s;
    assign o_stop_det  =  w_scl_s &  r_scl_d & ~r_sda_d &  w_sda_s;

endmodule

// File: rtl/i2c_codec_responder.sv
// I2C write-only target modelling the WM8731 control port: ACKs its address
// and two data bytes, then presents the 7-bit register address and 9-bit data.
module i2c_codec_responder
    import i2c_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR    = 7'h1A,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_sclk,
    input  logic       i_sdat,
    output logic       o_sdat,
    output logic       o_oen,
    output logic [6:0] o_reg_addr,
    output logic [8:0] o_reg_data,
    output logic       o_valid,
    output logic       o_busy,
    output logic       o_nack_err
);

    logic w_scl_rise;
    logic w_scl_fall;
    logic w_sda_s;
    logic w_start_det;
    logic w_stop_det;

    i2c_bus_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_bus_sync (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_sclk     (i_sclk),
        .i_sdat     (i_sdat),
        .o_scl_rise (w_scl_rise),
        .o_scl_fall (w_scl_fall),
        .o_sda_s    (w_sda_s),
        .o_start_det(w_start_det),
        .o_stop_det (w_stop_det)
    );

    i2c_rsp_state_e r_state, w_state_nx;
    logic [3:0] r_bit_cnt, w_bit_cnt_nx;
    logic [7:0] r_shift, w_shift_nx;
    logic [7:0] r_byte1, w_byte1_nx;
    logic [6:0] r_reg_addr, w_reg_addr_nx;
    logic [8:0] r_reg_data, w_reg_data_nx;
    logic       r_oen, w_oen_nx;
    logic       r_valid, w_valid_nx;
    logic       r_busy, w_busy_nx;
    logic       r_nack_err, w_nack_err_nx;
    logic       w_byte_done;

    assign w_byte_done = w_scl_fall && (r_bit_cnt == 4'd8);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_byte1    <= '0;
            r_reg_addr <= '0;
            r_reg_data <= '0;
            r_oen      <= 1'b0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_nack_err <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_bit_cnt  <= w_bit_cnt_nx;
            r_shift    <= w_shift_nx;
            r_byte1    <= w_byte1_nx;
            r_reg_addr <= w_reg_addr_nx;
            r_reg_data <= w_reg_data_nx;
            r_oen      <= w_oen_nx;
            r_valid    <= w_valid_nx;
            r_busy     <= w_busy_nx;
            r_nack_err <= w_nack_err_nx;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_bit_cnt_nx  = r_bit_cnt;
        w_shift_nx    = r_shift;
        w_byte1_nx    = r_byte1;
        w_reg_addr_nx = r_reg_addr;
        w_reg_data_nx = r_reg_data;
        w_oen_nx      = r_oen;
        w_valid_nx    = 1'b0;
        w_busy_nx     = r_busy;
        w_nack_err_nx = r_nack_err;

        // Bus conditions override any bit-level activity, including a repeated START
        if (w_start_det) begin
            w_state_nx   = ST_ADDR;
            w_bit_cnt_nx = '0;
            w_shift_nx   = '0;
            w_oen_nx     = 1'b0;
            w_busy_nx    = 1'b1;
        end else if (w_stop_det) begin
            if (r_state != ST_IDLE) begin
                w_state_nx = ST_IDLE;
                w_oen_nx   = 1'b0;
                w_busy_nx  = 1'b0;
            end
        end else begin
            case (r_state)
                ST_ADDR, ST_BYTE1, ST_BYTE2: begin
                    if (w_scl_rise && (r_bit_cnt < 4'd8)) begin
                        w_shift_nx   = {r_shift[6:0], w_sda_s};
                        w_bit_cnt_nx = r_bit_cnt + 4'd1;
                    end else if (w_byte_done) begin
                        w_bit_cnt_nx = '0;
                        if (r_state == ST_ADDR) begin
                            if (r_shift == {DEV_ADDR, 1'b0}) begin
                                w_state_nx = ST_ACK_ADDR;
                                w_oen_nx   = 1'b1;
                            end else begin
                                w_state_nx    = ST_NACK;
                                w_nack_err_nx = 1'b1;
                            end
                        end else if (r_state == ST_BYTE1) begin
                            w_byte1_nx = r_shift;
                            w_state_nx = ST_ACK1;
                            w_oen_nx   = 1'b1;
                        end else begin
                            w_reg_addr_nx = r_byte1[7:1];
                            w_reg_data_nx = {r_byte1[0], r_shift};
                            w_valid_nx    = 1'b1;
                            w_state_nx    = ST_ACK2;
                            w_oen_nx      = 1'b1;
                        end
                    end
                end
                ST_ACK_ADDR, ST_ACK1, ST_ACK2, ST_NACK: begin
                    if (w_scl_fall) begin
                        w_oen_nx     = 1'b0;
                        w_bit_cnt_nx = '0;
                        w_shift_nx   = '0;
                        case (r_state)
                            ST_ACK_ADDR: w_state_nx = ST_BYTE1;
                            ST_ACK1:     w_state_nx = ST_BYTE2;
                            default:     w_state_nx = ST_WAIT_STOP;
                        endcase
                    end
                end
                default: begin
                    w_oen_nx = 1'b0;
                end
            endcase
        end
    end

    assign o_sdat     = 1'b0;
    assign o_oen      = r_oen;
    assign o_reg_addr = r_reg_addr;
    assign o_reg_data = r_reg_data;
    assign o_valid    = r_valid;
    assign o_busy     = r_busy;
    assign o_nack_err = r_nack_err;

endmodule

// File: tb/tb_i2c_codec_responder.sv
// Directed bench for i2c_codec_responder: a bit-banged I2C master drives
// write transactions from a table, plus partial-word and reset corner cases.
module tb_i2c_codec_responder;

    localparam int Q = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic       sclk;
    logic       sdat;
    logic       o_sdat;
    logic       o_oen;
    logic [6:0] o_reg_addr;
    logic [8:0] o_reg_data;
    logic       o_valid;
    logic       o_busy;
    logic       o_nack_err;

    int n_cmp = 0;
    int n_err = 0;
    int valid_cnt = 0;
    logic oen_seen = 1'b0;
    logic prev_valid = 1'b0;

    always #5 clk = ~clk;

    i2c_codec_responder #(
        .DEV_ADDR(7'h1A),
        .SYNC_STAGES(2)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_sclk    (sclk),
        .i_sdat    (sdat),
        .o_sdat    (o_sdat),
        .o_oen     (o_oen),
        .o_reg_addr(o_reg_addr),
        .o_reg_data(o_reg_data),
        .o_valid   (o_valid),
        .o_busy    (o_busy),
        .o_nack_err(o_nack_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pulse monitor: every o_valid must be a single-cycle strobe
    always @(negedge clk) begin
        if (o_oen) oen_seen <= 1'b1;
        if (o_valid) begin
            valid_cnt++;
            chk("valid_width", {31'd0, prev_valid}, 32'd0);
        end
        if (o_sdat !== 1'b0) chk("sdat_tied_low", {31'd0, o_sdat}, 32'd0);
        prev_valid <= o_valid;
    end

    task automatic wq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        sdat = 1'b1; sclk = 1'b1; wq();
        sdat = 1'b0; wq();
        sclk = 1'b0; wq();
    endtask

    task automatic i2c_stop();
        sdat = 1'b0; wq();
        sclk = 1'b1; wq();
        sdat = 1'b1; wq();
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            sdat = b[i]; wq();
            sclk = 1'b1; wq(); wq();
            sclk = 1'b0; wq();
        end
    endtask

    task automatic ack_bit(output logic ack);
        sdat = 1'b1; wq();
        sclk = 1'b1; wq();
        ack = o_oen;
        wq();
        sclk = 1'b0; wq();
    endtask

    typedef struct {
        logic [7:0] b0, b1, b2;
        logic       a0, a1, a2;
        logic       v;
        logic [6:0] addr;
        logic [8:0] data;
    } vec_t;

    vec_t vecs[10];

    logic [6:0] exp_addr;
    logic [8:0] exp_data;
    logic       exp_nack;
    logic       k0, k1, k2;
    int         vc0;

    initial begin
        //            b0     b1     b2     a0    a1    a2    v     addr   data
        vecs[0] = '{8'h34, 8'h08, 8'h15, 1'b1, 1'b1, 1'b1, 1'b1, 7'd4,  9'h015};
        vecs[1] = '{8'h34, 8'h0A, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 7'd5,  9'h000};
        vecs[2] = '{8'h34, 8'h0C, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 7'd6,  9'h000};
        vecs[3] = '{8'h34, 8'h0E, 8'h42, 1'b1, 1'b1, 1'b1, 1'b1, 7'd7,  9'h042};
        vecs[4] = '{8'h34, 8'h10, 8'h19, 1'b1, 1'b1, 1'b1, 1'b1, 7'd8,  9'h019};
        vecs[5] = '{8'h34, 8'h12, 8'h01, 1'b1, 1'b1, 1'b1, 1'b1, 7'd9,  9'h001};
        vecs[6] = '{8'h36, 8'h0E, 8'h42, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0,  9'h000};
        vecs[7] = '{8'h34, 8'h14, 8'hAB, 1'b1, 1'b1, 1'b1, 1'b1, 7'd10, 9'h0AB};
        vecs[8] = '{8'h35, 8'h08, 8'h15, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0,  9'h000};
        vecs[9] = '{8'h34, 8'h1F, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 7'd15, 9'h1FF};

        rst = 1'b1; sclk = 1'b1; sdat = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_oen",  {31'd0, o_oen}, 32'd0);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_nack", {31'd0, o_nack_err}, 32'd0);
        chk("rst_addr", {25'd0, o_reg_addr}, 32'd0);
        chk("rst_data", {23'd0, o_reg_data}, 32'd0);
        rst = 1'b0;
        wq();

        exp_addr = '0; exp_data = '0; exp_nack = 1'b0;
        for (int i = 0; i < 10; i++) begin
            oen_seen = 1'b0;
            vc0 = valid_cnt;
            i2c_start();
            chk($sformatf("v%0d_busy_on", i), {31'd0, o_busy}, 32'd1);
            send_bits(vecs[i].b0, 8); ack_bit(k0);
            send_bits(vecs[i].b1, 8); ack_bit(k1);
            send_bits(vecs[i].b2, 8); ack_bit(k2);
            i2c_stop();
            wq();
            if (vecs[i].v) begin
                exp_addr = vecs[i].addr;
                exp_data = vecs[i].data;
            end
            if (!vecs[i].a0) exp_nack = 1'b1;
            chk($sformatf("v%0d_ack0", i), {31'd0, k0}, {31'd0, vecs[i].a0});
            chk($sformatf("v%0d_ack1", i), {31'd0, k1}, {31'd0, vecs[i].a1});
            chk($sformatf("v%0d_ack2", i), {31'd0, k2}, {31'd0, vecs[i].a2});
            chk($sformatf("v%0d_valid_cnt", i), valid_cnt - vc0, {31'd0, vecs[i].v});
            chk($sformatf("v%0d_addr", i), {25'd0, o_reg_addr}, {25'd0, exp_addr});
            chk($sformatf("v%0d_data", i), {23'd0, o_reg_data}, {23'd0, exp_data});
            chk($sformatf("v%0d_busy_off", i), {31'd0, o_busy}, 32'd0);
            chk($sformatf("v%0d_nack_err", i), {31'd0, o_nack_err}, {31'd0, exp_nack});
            chk($sformatf("v%0d_oen_seen", i), {31'd0, oen_seen},
                {31'd0, vecs[i].a0 | vecs[i].a1 | vecs[i].a2});
        end

        // Word abandoned by STOP partway through byte2
        vc0 = valid_cnt;
        i2c_start();
        send_bits(8'h34, 8); ack_bit(k0);
        send_bits(8'h0E, 8); ack_bit(k1);
        send_bits(8'hA5, 4);
        i2c_stop();
        wq();
        chk("part_ack0", {31'd0, k0}, 32'd1);
        chk("part_ack1", {31'd0, k1}, 32'd1);
        chk("part_no_valid", valid_cnt - vc0, 32'd0);
        chk("part_busy", {31'd0, o_busy}, 32'd0);
        chk("part_addr", {25'd0, o_reg_addr}, {25'd0, exp_addr});
        chk("part_data", {23'd0, o_reg_data}, {23'd0, exp_data});

        // Reset while the responder is driving the ACK1 bit
        i2c_start();
        send_bits(8'h34, 8); ack_bit(k0);
        send_bits(8'h0E, 8);
        chk("ack1_oen_before_rst", {31'd0, o_oen}, 32'd1);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_oen", {31'd0, o_oen}, 32'd0);
        chk("rst_mid_busy", {31'd0, o_busy}, 32'd0);
        @(negedge clk); rst = 1'b0;
        chk("rst_mid_nack", {31'd0, o_nack_err}, 32'd0);
        chk("rst_mid_addr", {25'd0, o_reg_addr}, 32'd0);
        sclk = 1'b0; wq();
        i2c_stop();
        wq();

        vc0 = valid_cnt;
        i2c_start();
        send_bits(8'h34, 8); ack_bit(k0);
        send_bits(8'h0E, 8); ack_bit(k1);
        send_bits(8'h42, 8); ack_bit(k2);
        i2c_stop();
        wq();
        chk("post_rst_ack0", {31'd0, k0}, 32'd1);
        chk("post_rst_ack2", {31'd0, k2}, 32'd1);
        chk("post_rst_valid", valid_cnt - vc0, 32'd1);
        chk("post_rst_addr", {25'd0, o_reg_addr}, 32'd7);
        chk("post_rst_data", {23'd0, o_reg_data}, 32'h042);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
